// File: rtl/fifo_rd_stream_adapter_pkg.sv
// ----------------------------------------------------------------------------
// fifo_rd_stream_adapter_pkg
//   Shared definitions for the FIFO read-side stream adapter and the FIFO
//   wrappers around it:
//     - FIFO output-mode strings and helpers to decode them
//     - rd_mode_e : decoded FIFO output mode
//     - count_width / ptr_width : width helpers derived from buffer depth
// ----------------------------------------------------------------------------
package fifo_rd_stream_adapter_pkg;

    localparam string FWFT_TRUE  = "true";
    localparam string FWFT_FALSE = "false";

    typedef enum logic {
        RD_MODE_REGISTERED = 1'b0,
        RD_MODE_FWFT       = 1'b1
    } rd_mode_e;

    function automatic bit fwft_is_true(input string mode);
        return mode == FWFT_TRUE;
    endfunction

    function automatic bit fwft_is_false(input string mode);
        return mode == FWFT_FALSE;
    endfunction

    // Width needed to hold values 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width needed to index 0..depth-1, never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// ----------------------------------------------------------------------------
// fifo_rd_stream_buf
//   Circular register buffer for the FIFO read stream adapter. Pointers wrap
//   at BufferDepth-1, so the depth need not be a power of two.
//   Ports:
//     clk       : read-domain clock
//     rst       : asynchronous active-low reset
//     i_wr_en   : write i_wr_data at the write pointer and advance it
//     i_wr_data : data to store
//     i_rd_en   : advance the read pointer (entry consumed)
//     o_rd_data : entry at the read pointer (flop outputs only)
// ----------------------------------------------------------------------------
module fifo_rd_stream_buf
    import fifo_rd_stream_adapter_pkg::*;
#(
    parameter int DataWidth   = 64,
    parameter int BufferDepth = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr_en,
    input  logic [DataWidth-1:0] i_wr_data,
    input  logic                 i_rd_en,
    output logic [DataWidth-1:0] o_rd_data
);

    localparam int                  PtrWidth = ptr_width(BufferDepth);
    localparam logic [PtrWidth-1:0] LastIdx  = PtrWidth'(BufferDepth - 1);

    logic [DataWidth-1:0] r_mem [BufferDepth];
    logic [PtrWidth-1:0]  r_wr_ptr;
    logic [PtrWidth-1:0]  r_rd_ptr;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == LastIdx) ? '0 : p + PtrWidth'(1);
    endfunction

    // Storage is cleared on reset so the stream data output reads zero while
    // the buffer is idle after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int unsigned i = 0; i < BufferDepth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_wr_en) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (i_rd_en) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
        end
    end

    always_comb begin
        o_rd_data = r_mem[r_rd_ptr];
    end

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// ----------------------------------------------------------------------------
// fifo_rd_stream_adapter
//   Read-clock-domain stage behind the dual-clock FIFO. Drives the FIFO native
//   read side and re-presents the data as a valid/ready stream through a small
//   registered buffer. Supports FWFT and registered FIFO output modes.
//   Ports:
//     clk           : read-domain clock (FIFO rd_clk)
//     rst           : asynchronous active-low reset (with FIFO rd_rst)
//     fifo_rd_req   : read request to the FIFO
//     fifo_rd_data  : FIFO read data
//     fifo_rd_empty : FIFO empty flag
//     m_data        : stream data (registered)
//     m_valid       : stream valid (registered)
//     m_ready       : stream consumer ready
//     occupancy     : entries held in the output buffer (registered)
// ----------------------------------------------------------------------------
module fifo_rd_stream_adapter
    import fifo_rd_stream_adapter_pkg::*;
#(
    parameter int    DataWidth            = 64,
    parameter string FirstWordFallThrough = "true",
    parameter int    BufferDepth          = 3,
    parameter int    CountWidth           = count_width(BufferDepth)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_rd_req,
    input  logic [DataWidth-1:0]  fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic [DataWidth-1:0]  m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CountWidth-1:0] occupancy
);

    localparam rd_mode_e Mode = fwft_is_false(FirstWordFallThrough) ?
                                RD_MODE_REGISTERED : RD_MODE_FWFT;
    localparam int                  SumWidth   = CountWidth + 1;
    localparam logic [SumWidth-1:0] DepthLimit = SumWidth'(BufferDepth);

    logic [CountWidth-1:0] r_count;
    logic                  r_pending;

    logic [SumWidth-1:0]   w_committed;
    logic                  w_issue;
    logic                  w_land;
    logic                  w_pop;

    // Issue only when the buffer has room for everything already committed
    // (stored plus in flight). No pop lookahead keeps m_ready off this path.
    // Gating with rst holds the request low while reset is asserted.
    always_comb begin
        w_committed = SumWidth'(r_count) + SumWidth'(r_pending);
        w_issue     = rst & ~fifo_rd_empty & (w_committed < DepthLimit);
    end

    // FWFT data is valid alongside the request; registered data arrives one
    // cycle after it, tracked by r_pending.
    always_comb begin
        w_land = (Mode == RD_MODE_FWFT) ? w_issue : r_pending;
    end

    always_comb begin
        m_valid     = (r_count != '0);
        w_pop       = m_valid & m_ready;
        fifo_rd_req = w_issue;
        occupancy   = r_count;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count   <= '0;
            r_pending <= 1'b0;
        end else begin
            r_pending <= (Mode == RD_MODE_REGISTERED) ? w_issue : 1'b0;
            unique case ({w_land, w_pop})
                2'b10:   r_count <= r_count + CountWidth'(1);
                2'b01:   r_count <= r_count - CountWidth'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    fifo_rd_stream_buf #(
        .DataWidth   (DataWidth),
        .BufferDepth (BufferDepth)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_land),
        .i_wr_data (fifo_rd_data),
        .i_rd_en   (w_pop),
        .o_rd_data (m_data)
    );

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// ----------------------------------------------------------------------------
// tb_fifo_rd_stream_adapter
//   Three adapter instances: FWFT depth 3, registered depth 3, registered
//   depth 2. One is active per test; a queue-based FIFO model feeds it and a
//   queue model of the output buffer predicts every stream output.
// ----------------------------------------------------------------------------
module tb_fifo_rd_stream_adapter;

    localparam int DW = 16;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [NI-1:0] req, empty, valid, ready;
    logic [DW-1:0] rdata [NI];
    logic [DW-1:0] mdata [NI];
    logic [1:0]    occ   [NI];

    fifo_rd_stream_adapter #(
        .DataWidth(DW), .FirstWordFallThrough("true"), .BufferDepth(3)
    ) u_fwft3 (
        .clk(clk), .rst(rst), .fifo_rd_req(req[0]), .fifo_rd_data(rdata[0]),
        .fifo_rd_empty(empty[0]), .m_data(mdata[0]), .m_valid(valid[0]),
        .m_ready(ready[0]), .occupancy(occ[0])
    );

    fifo_rd_stream_adapter #(
        .DataWidth(DW), .FirstWordFallThrough("false"), .BufferDepth(3)
    ) u_reg3 (
        .clk(clk), .rst(rst), .fifo_rd_req(req[1]), .fifo_rd_data(rdata[1]),
        .fifo_rd_empty(empty[1]), .m_data(mdata[1]), .m_valid(valid[1]),
        .m_ready(ready[1]), .occupancy(occ[1])
    );

    fifo_rd_stream_adapter #(
        .DataWidth(DW), .FirstWordFallThrough("false"), .BufferDepth(2)
    ) u_reg2 (
        .clk(clk), .rst(rst), .fifo_rd_req(req[2]), .fifo_rd_data(rdata[2]),
        .fifo_rd_empty(empty[2]), .m_data(mdata[2]), .m_valid(valid[2]),
        .m_ready(ready[2]), .occupancy(occ[2])
    );

    // Model state for the active instance
    int            cur;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] buf_q[$];
    bit            infl_v;
    logic [DW-1:0] infl_d, reg_out;
    bit            prev_req;

    // Observed statistics
    int            cyc, first_req, first_valid, first_pop, last_pop;
    int            n_pop, n_req, max_gap, max_occ;
    logic [DW-1:0] first_pop_data;

    int n_cmp = 0;
    int n_err = 0;

    function automatic int depth_of(input int i);
        return (i == 2) ? 2 : 3;
    endfunction

    function automatic bit fwft_of(input int i);
        return i == 0;
    endfunction

    task automatic clear_stats();
        cyc = 0; first_req = -1; first_valid = -1; first_pop = -1; last_pop = -1;
        n_pop = 0; n_req = 0; max_gap = 0; max_occ = 0; first_pop_data = '0;
    endtask

    task automatic clear_model();
        fifo_q.delete(); buf_q.delete();
        infl_v = 1'b0; infl_d = '0; reg_out = '0; prev_req = 1'b0;
    endtask

    task automatic apply_reset(input int idx);
        cur = idx;
        clear_model();
        clear_stats();
        rst = 1'b0; empty = '1; ready = '0;
        for (int i = 0; i < NI; i++) rdata[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance model.
    task automatic step(input bit rdy, input bit hide);
        bit exp_req, exp_valid, m_pop;
        int d;
        d = depth_of(cur);
        ready[cur] = rdy;
        empty[cur] = hide || (fifo_q.size() == 0);
        if (fwft_of(cur)) rdata[cur] = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        else              rdata[cur] = reg_out;
        @(negedge clk);
        exp_req   = !empty[cur] && ((buf_q.size() + int'(infl_v)) < d);
        exp_valid = (buf_q.size() != 0);

        n_cmp++;
        if (req[cur] !== exp_req) begin
            n_err++;
            $display("FAIL rd_req inst%0d cyc%0d: got %b want %b", cur, cyc, req[cur], exp_req);
        end
        n_cmp++;
        if (valid[cur] !== exp_valid) begin
            n_err++;
            $display("FAIL m_valid inst%0d cyc%0d: got %b want %b", cur, cyc, valid[cur], exp_valid);
        end
        n_cmp++;
        if (occ[cur] !== 2'(buf_q.size())) begin
            n_err++;
            $display("FAIL occupancy inst%0d cyc%0d: got %0d want %0d", cur, cyc, occ[cur], buf_q.size());
        end
        if (exp_valid) begin
            n_cmp++;
            if (mdata[cur] !== buf_q[0]) begin
                n_err++;
                $display("FAIL m_data inst%0d cyc%0d: got %h want %h", cur, cyc, mdata[cur], buf_q[0]);
            end
        end
        n_cmp++;
        if (req[cur] === 1'b1 && empty[cur] === 1'b1) begin
            n_err++;
            $display("FAIL req_while_empty inst%0d cyc%0d: got req=1 want req=0", cur, cyc);
        end
        n_cmp++;
        if (int'(occ[cur]) + int'(prev_req && !fwft_of(cur)) > d) begin
            n_err++;
            $display("FAIL overflow inst%0d cyc%0d: got count+pending=%0d want <=%0d",
                     cur, cyc, int'(occ[cur]) + int'(prev_req && !fwft_of(cur)), d);
        end

        if (req[cur] === 1'b1) begin
            n_req++;
            if (first_req < 0) first_req = cyc;
        end
        if (valid[cur] === 1'b1 && first_valid < 0) first_valid = cyc;
        if (valid[cur] === 1'b1 && rdy) begin
            if (first_pop < 0) begin
                first_pop      = cyc;
                first_pop_data = mdata[cur];
            end else if (cyc - last_pop > max_gap) begin
                max_gap = cyc - last_pop;
            end
            last_pop = cyc;
            n_pop++;
        end
        if (first_valid >= 0 && int'(occ[cur]) > max_occ) max_occ = int'(occ[cur]);
        prev_req = (req[cur] === 1'b1);
        m_pop    = exp_valid && rdy;

        @(posedge clk);
        #1;
        if (m_pop) void'(buf_q.pop_front());
        if (fwft_of(cur)) begin
            if (exp_req) buf_q.push_back(fifo_q.pop_front());
        end else begin
            if (infl_v) buf_q.push_back(infl_d);
            infl_v = exp_req;
            if (exp_req) begin
                infl_d  = fifo_q.pop_front();
                reg_out = infl_d;
            end
        end
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b0; empty = '0; ready = '1;
        for (int i = 0; i < NI; i++) rdata[i] = DW'(16'hBEEF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (req[i] !== 1'b0) begin n_err++; $display("FAIL reset_req inst%0d: got %b want 0", i, req[i]); end
            n_cmp++;
            if (valid[i] !== 1'b0) begin n_err++; $display("FAIL reset_valid inst%0d: got %b want 0", i, valid[i]); end
            n_cmp++;
            if (occ[i] !== 2'd0) begin n_err++; $display("FAIL reset_occ inst%0d: got %0d want 0", i, occ[i]); end
            n_cmp++;
            if (mdata[i] !== '0) begin n_err++; $display("FAIL reset_data inst%0d: got %h want 0", i, mdata[i]); end
        end
    endtask

    task automatic test_fwft_stream();
        apply_reset(0);
        for (int i = 0; i < 5; i++) fifo_q.push_back(DW'(8'hA0 + i));
        repeat (12) step(1'b1, 1'b0);
        n_cmp++;
        if (n_pop != 5) begin n_err++; $display("FAIL fwft_beats: got %0d want 5", n_pop); end
        n_cmp++;
        if (first_valid - first_req != 1) begin
            n_err++; $display("FAIL fwft_latency: got %0d want 1", first_valid - first_req);
        end
        n_cmp++;
        if (last_pop - first_pop != 4) begin
            n_err++; $display("FAIL fwft_back_to_back: got span %0d want 4", last_pop - first_pop);
        end
        n_cmp++;
        if (max_occ > 1) begin n_err++; $display("FAIL fwft_max_occ: got %0d want <=1", max_occ); end
    endtask

    task automatic test_registered_stream();
        apply_reset(1);
        for (int i = 0; i < 5; i++) fifo_q.push_back(DW'(8'hA0 + i));
        repeat (12) step(1'b1, 1'b0);
        n_cmp++;
        if (n_pop != 5) begin n_err++; $display("FAIL reg_beats: got %0d want 5", n_pop); end
        n_cmp++;
        if (first_valid - first_req != 2) begin
            n_err++; $display("FAIL reg_latency: got %0d want 2", first_valid - first_req);
        end
        n_cmp++;
        if (last_pop - first_pop != 4) begin
            n_err++; $display("FAIL reg_back_to_back: got span %0d want 4", last_pop - first_pop);
        end
    endtask

    task automatic test_backpressure();
        apply_reset(1);
        for (int i = 0; i < 10; i++) fifo_q.push_back(DW'(16'h0100 + i));
        repeat (8) step(1'b0, 1'b0);
        n_cmp++;
        if (n_req != 3) begin n_err++; $display("FAIL bp_req_pulses: got %0d want 3", n_req); end
        n_cmp++;
        if (occ[1] !== 2'd3) begin n_err++; $display("FAIL bp_occ_full: got %0d want 3", occ[1]); end
        for (int k = 0; k < 40 && n_pop < 10; k++) step(1'b1, 1'b0);
        n_cmp++;
        if (n_pop != 10) begin n_err++; $display("FAIL bp_beats: got %0d want 10", n_pop); end
        n_cmp++;
        if (last_pop - first_pop != 9) begin
            n_err++; $display("FAIL bp_no_gaps: got span %0d want 9", last_pop - first_pop);
        end
    endtask

    task automatic test_empty_toggle(input int idx);
        apply_reset(idx);
        for (int i = 0; i < 40; i++) fifo_q.push_back(DW'($urandom));
        for (int k = 0; k < 120; k++) step(1'($urandom_range(0, 1)), (cyc % 2) == 1);
        for (int k = 0; k < 60 && n_pop < 40; k++) step(1'b1, 1'b0);
        n_cmp++;
        if (n_pop != 40) begin n_err++; $display("FAIL toggle_beats inst%0d: got %0d want 40", idx, n_pop); end
        n_cmp++;
        if (valid[idx] !== 1'b0) begin
            n_err++; $display("FAIL toggle_drained inst%0d: got valid %b want 0", idx, valid[idx]);
        end
    endtask

    task automatic test_reset_midop();
        apply_reset(1);
        for (int i = 0; i < 6; i++) fifo_q.push_back(DW'(16'h0200 + i));
        repeat (3) step(1'b0, 1'b0);
        #2;
        n_cmp++;
        if (occ[1] !== 2'd2) begin n_err++; $display("FAIL midop_occ_before: got %0d want 2", occ[1]); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (valid[1] !== 1'b0) begin n_err++; $display("FAIL midop_async_valid: got %b want 0", valid[1]); end
        n_cmp++;
        if (occ[1] !== 2'd0) begin n_err++; $display("FAIL midop_async_occ: got %0d want 0", occ[1]); end
        n_cmp++;
        if (req[1] !== 1'b0) begin n_err++; $display("FAIL midop_async_req: got %b want 0", req[1]); end
        clear_model();
        clear_stats();
        fifo_q.push_back(DW'(16'h00B0));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 10 && n_pop < 1; k++) step(1'b1, 1'b0);
        n_cmp++;
        if (n_pop != 1) begin n_err++; $display("FAIL midop_beats: got %0d want 1", n_pop); end
        n_cmp++;
        if (first_pop_data !== DW'(16'h00B0)) begin
            n_err++; $display("FAIL midop_first_beat: got %h want 00b0", first_pop_data);
        end
    endtask

    task automatic test_depth2_throughput();
        apply_reset(2);
        for (int i = 0; i < 30; i++) fifo_q.push_back(DW'(16'h0300 + i));
        for (int k = 0; k < 100 && n_pop < 30; k++) step(1'b1, 1'b0);
        n_cmp++;
        if (n_pop != 30) begin n_err++; $display("FAIL d2_beats: got %0d want 30", n_pop); end
        n_cmp++;
        if (max_gap > 2) begin n_err++; $display("FAIL d2_gap: got max gap %0d want <=2", max_gap); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fwft_stream();
        test_registered_stream();
        test_backpressure();
        test_empty_toggle(0);
        test_empty_toggle(1);
        test_empty_toggle(2);
        test_reset_midop();
        test_depth2_throughput();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
